// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller_if
// Description : Bundle of the interrupt lines, mask-write port and core
//               ExtIRQ/ExtIAck/ERet handshake around irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_controller_if #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
);
  logic [NSRC-1:0] irq_in;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            ExtIAck;
  logic            ERet;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic            in_service;

  // Controller side
  modport slave (
    input  irq_in, mask_we, mask_wdata, ExtIAck, ERet,
    output ExtIRQ, irq_id, pending, enable, in_service
  );

  // Core / interrupt-source side
  modport master (
    output irq_in, mask_we, mask_wdata, ExtIAck, ERet,
    input  ExtIRQ, irq_id, pending, enable, in_service
  );
endinterface
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Multi-source external interrupt controller. Synchronises and
//               edge-detects asynchronous lines, latches pending bits, gates
//               them with an enable mask, picks the lowest-index candidate and
//               runs one request at a time through the core handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  wire logic         CLOCK_50,
  input  wire logic         reset,
  irq_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          state_q;
  logic [NSRC-1:0] sync1_q;
  logic [NSRC-1:0] sync2_q;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] enable_q;
  logic            ExtIRQ_q;
  logic [IDW-1:0]  irq_id_q;
  logic            in_service_q;

  logic [NSRC-1:0] w_event;
  logic [NSRC-1:0] w_cand;
  logic [IDW-1:0]  w_winner;
  logic            w_ack;
  logic [NSRC-1:0] w_clr;

  // Two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_event = sync2_q & ~prev_q;

  // Acknowledge only counts while a request is outstanding
  assign w_ack = (state_q == S_REQ) && bus.ExtIAck;

  // Pending next state: clear the acknowledged source, a fresh edge wins
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clr[i] = w_ack && (irq_id_q == IDW'(i));
    end
    pending_d = (pending_q & ~w_clr) | w_event;
  end

  // Pending bits latch regardless of the mask
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Enable mask register, written by the strobe
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      enable_q <= '0;
    end else if (bus.mask_we) begin
      enable_q <= bus.mask_wdata;
    end
  end

  // Fixed priority: lowest set candidate index wins
  always_comb begin
    w_cand   = pending_q & enable_q;
    w_winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_winner = IDW'(i);
      end
    end
  end

  // Request/acknowledge/return sequencer with registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ExtIRQ_q     <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|w_cand) begin
            irq_id_q <= w_winner;
            ExtIRQ_q <= 1'b1;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          // Request is held even if the source gets masked meanwhile
          if (bus.ExtIAck) begin
            ExtIRQ_q     <= 1'b0;
            in_service_q <= 1'b1;
            state_q      <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          // No nesting: new events only accumulate in pending
          if (bus.ERet) begin
            in_service_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          ExtIRQ_q     <= 1'b0;
          in_service_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ExtIRQ     = ExtIRQ_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.pending    = pending_q;
  assign bus.enable     = enable_q;
  assign bus.in_service = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic CLOCK_50;
  logic reset;
  int   vectors;
  int   miscompares;
  int   seen_irq;

  irq_controller_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

  irq_controller #(.NSRC(NSRC), .IDW(IDW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One rising edge, then settle 1 ns past it
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [NSRC-1:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ExtIAck    = 1'b0;
    bus.ERet       = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_extirq",  16'(bus.ExtIRQ),     16'h0);
    check("rst_id",      16'(bus.irq_id),     16'h0);
    check("rst_pending", 16'(bus.pending),    16'h0);
    check("rst_enable",  16'(bus.enable),     16'h0);
    check("rst_insvc",   16'(bus.in_service), 16'h0);
    reset = 1'b1;
    repeat (2) tick();

    // ---- Single source, enable = 0010 ----
    write_mask(4'b0010);
    check("s_enable", 16'(bus.enable), 16'h2);
    bus.irq_in[1] = 1'b1;            // before E0
    tick(); tick();                  // E0, E1
    check("s_pend_e1", 16'(bus.pending), 16'h0);
    tick();                          // E2
    check("s_pend_e2", 16'(bus.pending), 16'h2);
    check("s_irq_e2",  16'(bus.ExtIRQ),  16'h0);
    tick();                          // E3
    check("s_irq_e3",  16'(bus.ExtIRQ),  16'h1);
    check("s_id_e3",   16'(bus.irq_id),  16'h1);
    // ERet while requesting is ignored
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    check("s_eret_req_irq",   16'(bus.ExtIRQ),     16'h1);
    check("s_eret_req_insvc", 16'(bus.in_service), 16'h0);
    // Acknowledge
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    check("s_ack_irq",   16'(bus.ExtIRQ),     16'h0);
    check("s_ack_pend",  16'(bus.pending),    16'h0);
    check("s_ack_insvc", 16'(bus.in_service), 16'h1);
    check("s_ack_id",    16'(bus.irq_id),     16'h1);
    // ExtIAck during service is ignored
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    check("s_svc_ack_insvc", 16'(bus.in_service), 16'h1);
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    check("s_eret_insvc", 16'(bus.in_service), 16'h0);
    tick();
    check("s_level_once", 16'(bus.ExtIRQ), 16'h0);
    bus.irq_in = '0;
    repeat (4) tick();
    // Spurious ack in IDLE
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    check("s_idle_ack_insvc", 16'(bus.in_service), 16'h0);
    check("s_idle_ack_irq",   16'(bus.ExtIRQ),     16'h0);

    // ---- Priority, enable = F ----
    write_mask(4'hF);
    bus.irq_in = 4'b1010;
    repeat (4) tick();
    check("p_irq1",  16'(bus.ExtIRQ),  16'h1);
    check("p_id1",   16'(bus.irq_id),  16'h1);
    check("p_pend1", 16'(bus.pending), 16'hA);
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    check("p_ack_pend", 16'(bus.pending), 16'h8);
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    check("p_gap_irq", 16'(bus.ExtIRQ), 16'h0);
    tick();
    check("p_irq3", 16'(bus.ExtIRQ), 16'h1);
    check("p_id3",  16'(bus.irq_id), 16'h3);
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    bus.irq_in = '0;
    repeat (4) tick();
    check("p_done_pend", 16'(bus.pending), 16'h0);

    // ---- Masking, enable = 0000 ----
    write_mask(4'b0000);
    bus.irq_in[2] = 1'b1;
    repeat (3) tick();
    check("m_pend", 16'(bus.pending), 16'h4);
    seen_irq = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ExtIRQ) seen_irq++;
    end
    check("m_quiet", 16'(seen_irq), 16'h0);
    write_mask(4'b0100);
    check("m_wr_irq", 16'(bus.ExtIRQ), 16'h0);
    tick();
    check("m_irq", 16'(bus.ExtIRQ), 16'h1);
    check("m_id",  16'(bus.irq_id), 16'h2);
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    check("m_ack_insvc", 16'(bus.in_service), 16'h1);

    // ---- No nesting during service of source 2 ----
    write_mask(4'b0101);
    bus.irq_in[0] = 1'b1;
    repeat (3) tick();
    check("n_pend", 16'(bus.pending), 16'h1);
    seen_irq = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ExtIRQ) seen_irq++;
    end
    check("n_quiet", 16'(seen_irq),   16'h0);
    check("n_id2",   16'(bus.irq_id), 16'h2);
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    check("n_eret_insvc", 16'(bus.in_service), 16'h0);
    tick();
    check("n_irq0", 16'(bus.ExtIRQ), 16'h1);
    check("n_id0",  16'(bus.irq_id), 16'h0);
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    bus.irq_in = '0;
    repeat (4) tick();

    // ---- Set wins over clear on source 1 ----
    write_mask(4'b0010);
    bus.irq_in[1] = 1'b1;
    repeat (4) tick();
    check("c_irq", 16'(bus.ExtIRQ), 16'h1);
    bus.irq_in[1] = 1'b0;
    repeat (3) tick();
    bus.irq_in[1] = 1'b1;
    tick(); tick();                  // G0, G1: event now live
    bus.ExtIAck = 1'b1; tick(); bus.ExtIAck = 1'b0;  // G2
    check("c_pend",  16'(bus.pending),    16'h2);
    check("c_insvc", 16'(bus.in_service), 16'h1);
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
    check("c_irq2", 16'(bus.ExtIRQ), 16'h1);
    check("c_id2",  16'(bus.irq_id), 16'h1);

    // ---- Asynchronous reset mid-REQ ----
    #2;
    reset = 1'b0;
    #1;
    check("r_irq",     16'(bus.ExtIRQ),     16'h0);
    check("r_pend",    16'(bus.pending),    16'h0);
    check("r_enable",  16'(bus.enable),     16'h0);
    check("r_id",      16'(bus.irq_id),     16'h0);
    check("r_insvc",   16'(bus.in_service), 16'h0);
    bus.irq_in = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    write_mask(4'hF);
    seen_irq = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ExtIRQ) seen_irq++;
    end
    check("r_no_req",  16'(seen_irq),    16'h0);
    check("r_no_pend", 16'(bus.pending), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Multi-source external interrupt controller in front of the single-cycle ARM core's ExtIRQ/ExtIAck exception interface.
- Synchronises and edge-detects NSRC asynchronous interrupt lines, latches them as pending, and gates them with a writable enable mask.
- Arbitrates by fixed priority, then sequences one request at a time through the core's request → acknowledge → exception-return handshake.
- Presents the serviced source ID so the exception handler can identify the cause.

Parameters:
- NSRC, 4, number of interrupt sources (2..16).
- IDW, 2, width of the source ID; must satisfy 2**IDW >= NSRC.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NSRC  raw external interrupt lines, asynchronous, rising-edge significant.
- mask_we  in  1  enable-mask write strobe.
- mask_wdata  in  NSRC  new enable mask (1 = source enabled).
- ExtIAck  in  1  core acknowledges the external interrupt (exception taken).
- ERet  in  1  core is executing an exception return this cycle.
- ExtIRQ  out  1  registered interrupt request to the core.
- irq_id  out  IDW  index of the source currently requested or in service.
- pending  out  NSRC  pending bits.
- enable  out  NSRC  current enable mask.
- in_service  out  1  high while the handler for irq_id runs.

Behaviour:
- Reset (reset=0, asynchronous): ExtIRQ=0, irq_id=0, pending=0, enable=0, in_service=0. Synchroniser and edge flops are cleared and the FSM goes to IDLE. Reset mid-handshake abandons the request with no residue.
- Input path, per bit: 2-flop synchroniser sync1→sync2, plus a delay flop prev. An edge event is sync2 & ~prev.
  - irq_in rising before edge E0 sets pending at E2.
  - A level held high produces exactly one event.
  - Pulses shorter than one clock period are not guaranteed to be captured.
- pending[i]:
  - Set by an edge event on source i.
  - Cleared when the core acknowledges source i (see REQ).
  - Set wins over clear in the same cycle.
  - Masked sources still latch pending; the mask only gates arbitration.
- enable: loaded from mask_wdata on an edge where mask_we=1. The new value affects arbitration from the next cycle.
- Arbitration: the candidate vector is pending & enable. The winner is the lowest set index (source 0 has highest priority), computed combinationally.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if the candidate vector is non-zero, at the next edge latch irq_id=winner, set ExtIRQ=1, go to REQ. ExtIAck and ERet are ignored.
  - REQ: hold ExtIRQ=1 and irq_id stable until ExtIAck=1. The request is never withdrawn, even if the source is masked meanwhile.
    - On the ExtIAck edge: ExtIRQ=0, pending[irq_id] cleared, in_service=1, go to SERVICE.
    - ERet in REQ is ignored.
  - SERVICE: no nesting; new events only accumulate in pending. irq_id stays stable.
    - On an edge with ERet=1: in_service=0, go to IDLE.
    - ExtIAck in SERVICE is ignored.
- Back-to-back: after ERet, if candidates remain, ExtIRQ reasserts on the second edge (IDLE re-arbitrates for one cycle). Minimum spacing between requests is 1 idle cycle.
- Latency:
  - Edge on irq_in before E0 → ExtIRQ high after E3 (enabled source, FSM idle).
  - ExtIAck sampled at edge → ExtIRQ low after the same edge.
- Priority is re-evaluated only in IDLE. A higher-priority event arriving during REQ or SERVICE waits.
- All outputs are registered or decoded directly from registers; no combinational path from inputs to ExtIRQ.

Test Plan:
- Reset check: drive reset=0 asynchronously mid-REQ with ExtIRQ=1 → all outputs 0 immediately. After release, no request is generated until a new irq_in edge.
- Single source with enable=4'b0010:
  - Raise irq_in[1] before E0 → pending=4'b0010 after E2; ExtIRQ=1, irq_id=1 after E3.
  - Assert ExtIAck for one cycle → ExtIRQ=0, pending=0, in_service=1.
  - Assert ERet → in_service=0, FSM idle.
- Priority with enable=4'hF: raise irq_in[3] and irq_in[1] together → irq_id=1 first.
  - After ack and ERet → irq_id=3, ExtIRQ reasserted 2 edges after ERet.
- Masking with enable=4'b0000: raise irq_in[2] → pending[2]=1, ExtIRQ stays 0 for 20 cycles.
  - Write mask_wdata=4'b0100 → ExtIRQ=1, irq_id=2 two edges after the write edge.
- No nesting / ignored strobes:
  - During SERVICE of source 2, raise irq_in[0] → pending[0]=1, ExtIRQ stays 0 until ERet, then irq_id=0.
  - Spurious ExtIAck in IDLE and ERet in REQ → no state change.
- Set-over-clear: time a new irq_in[1] edge event to coincide with the ExtIAck edge for source 1 → pending[1] remains 1 and a second request for ID 1 follows the ERet.
